// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module   : mem_access_ctrl
// Purpose  : Memory-stage load/store sequencer. Turns a single LDR/STR from the
//            control unit into one memory request, freezes the upstream pipeline
//            while the request is outstanding, and reports the load result or a
//            fault (misaligned word access or memory timeout) in a one-cycle
//            DONE slot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   TIMEOUT     maximum REQ-state cycles to wait for mem_ready (1..15)
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   datamem_en  load/store present in the memory stage
//   rw          1 = load, 0 = store
//   size        1 = byte, 0 = word
//   addr        effective address
//   st_data     store data
//   mem_ready   memory completed the current request
//   mem_rdata   memory read word, valid with mem_ready
//   mem_req     registered request to memory
//   mem_we      registered write enable
//   mem_addr    registered word-aligned address
//   mem_wdata   registered write data (byte stores replicated to all lanes)
//   mem_be      registered byte enables, little-endian lanes
//   stall       combinational pipeline freeze
//   load_valid  one-cycle pulse, load_data valid
//   load_data   registered load result, byte loads zero-extended
//   fault       00 none, 01 misaligned word, 10 timeout (nonzero only in DONE)
//==============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        datamem_en,
    input  logic        rw,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [1:0]  fault
);

    //--------------------------------------------------------------------------
    // State encoding and constants
    //--------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] c_FAULT_NONE    = 2'b00;
    localparam logic [1:0] c_FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

    // Last wait-count value before giving up on the memory.
    localparam logic [3:0] c_LAST_WAIT = 4'(TIMEOUT - 1);

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_rw;
    logic        r_size;
    logic [1:0]  r_lane;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic [1:0]  r_fault;

    //--------------------------------------------------------------------------
    // Request formation from the incoming instruction
    //--------------------------------------------------------------------------
    logic        w_aligned;
    logic [3:0]  w_be_req;
    logic [31:0] w_wdata_req;

    // Byte accesses can never be misaligned; words need addr[1:0] == 00.
    assign w_aligned = size | (addr[1:0] == 2'b00);

    always_comb begin
        w_be_req    = 4'b1111;
        w_wdata_req = st_data;
        if (size) begin
            // One-hot lane enable; the byte is replicated so the memory picks
            // it up on whichever lane is enabled.
            w_be_req    = 4'b0001 << addr[1:0];
            w_wdata_req = {4{st_data[7:0]}};
        end
    end

    //--------------------------------------------------------------------------
    // Load result formation from the memory response
    //--------------------------------------------------------------------------
    logic [7:0]  w_rd_byte;
    logic [31:0] w_load_result;
    logic        w_wait_expired;

    always_comb begin
        w_rd_byte = mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_rd_byte = mem_rdata[7:0];
            2'd1:    w_rd_byte = mem_rdata[15:8];
            2'd2:    w_rd_byte = mem_rdata[23:16];
            default: w_rd_byte = mem_rdata[31:24];
        endcase
    end

    assign w_load_result  = r_size ? {24'b0, w_rd_byte} : mem_rdata;
    assign w_wait_expired = (r_wait_cnt == c_LAST_WAIT);

    //--------------------------------------------------------------------------
    // Sequencer
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_rw         <= 1'b0;
            r_size       <= 1'b0;
            r_lane       <= 2'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_be     <= 4'b0000;
            r_load_valid <= 1'b0;
            r_load_data  <= 32'd0;
            r_fault      <= c_FAULT_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (datamem_en) begin
                        if (w_aligned) begin
                            r_rw        <= rw;
                            r_size      <= size;
                            r_lane      <= addr[1:0];
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= ~rw;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata_req;
                            r_mem_be    <= w_be_req;
                            r_wait_cnt  <= 4'd0;
                            r_state     <= S_REQ;
                        end else begin
                            // Misaligned word: nothing goes to memory, the
                            // fault is reported in the DONE slot.
                            r_fault <= c_FAULT_ALIGN;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    // Request fields stay untouched here so the memory sees a
                    // stable request; only mem_req drops on completion.
                    if (mem_ready) begin
                        // Ready wins even on the final wait cycle.
                        r_mem_req <= 1'b0;
                        r_fault   <= c_FAULT_NONE;
                        if (r_rw) begin
                            r_load_data  <= w_load_result;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (w_wait_expired) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= c_FAULT_TIMEOUT;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                S_DONE: begin
                    // datamem_en still reflects the instruction that is just
                    // leaving the stage, so it is not examined here.
                    r_load_valid <= 1'b0;
                    r_fault      <= c_FAULT_NONE;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_mem_req    <= 1'b0;
                    r_load_valid <= 1'b0;
                    r_fault      <= c_FAULT_NONE;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // Stall must assert in the same cycle the instruction arrives, hence the
    // combinational path from datamem_en.
    assign stall      = ((r_state == S_IDLE) & datamem_en) | (r_state == S_REQ);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign load_valid = r_load_valid;
    assign load_data  = r_load_data;
    assign fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl (TIMEOUT = 4). Expected
//            completions are queued when a transaction is launched and popped
//            when the DUT reports load_valid or a fault.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int unsigned c_TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic        datamem_en;
    logic        rw;
    logic        size;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic [1:0]  fault;

    mem_access_ctrl #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .datamem_en (datamem_en),
        .rw         (rw),
        .size       (size),
        .addr       (addr),
        .st_data    (st_data),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected DONE-slot reports.
    typedef struct {
        logic        lv;
        logic [31:0] data;
        logic [1:0]  flt;
    } exp_t;
    exp_t sb_q[$];

    // Observations collected by run_txn.
    logic [63:0] stall_bits;
    int          n_req;
    int          lv_cycle;
    int          done_cycle;
    logic        unstable;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    function automatic logic [31:0] byte_of(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] s;
        s = w >> (8 * lane);
        return {24'b0, s[7:0]};
    endfunction

    function automatic void push_exp(input logic lv, input logic [31:0] d, input logic [1:0] f);
        exp_t e;
        e.lv = lv; e.data = d; e.flt = f;
        sb_q.push_back(e);
    endfunction

    // Scoreboard monitor: any visible DONE report must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (load_valid === 1'b1 || fault !== 2'b00)) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: load_valid=%b fault=%b load_data=%h, required no report",
                         load_valid, fault, load_data);
            end else begin
                e = sb_q.pop_front();
                if (load_valid !== e.lv || fault !== e.flt || (e.lv && load_data !== e.data)) begin
                    errors++;
                    $display("FAIL sb_report: got lv=%b fault=%b data=%h, required lv=%b fault=%b data=%h",
                             load_valid, fault, load_data, e.lv, e.flt, e.data);
                end
            end
        end
    end

    // Launch one instruction at posedge+1 and follow it through DONE. The memory
    // answers on the REQ cycle numbered 'waits' (0 = first); large = never.
    task automatic run_txn(input logic t_rw, input logic t_size, input logic [31:0] t_addr,
                           input logic [31:0] t_st, input logic [31:0] t_rdata, input int waits);
        stall_bits = '0; n_req = 0; lv_cycle = -1; done_cycle = -1; unstable = 1'b0;
        seen_addr = '0; seen_wdata = '0; seen_be = '0; seen_we = 1'b0;
        datamem_en = 1'b1; rw = t_rw; size = t_size; addr = t_addr; st_data = t_st;
        for (int c = 1; c <= 40 && done_cycle < 0; c++) begin
            if (mem_req === 1'b1 && n_req == waits) begin
                mem_ready = 1'b1; mem_rdata = t_rdata;
            end else begin
                mem_ready = 1'b0; mem_rdata = ~t_rdata;
            end
            @(negedge clk);
            stall_bits[c] = stall;
            if (load_valid === 1'b1) lv_cycle = c;
            if (mem_req === 1'b1) begin
                if (n_req == 0) begin
                    seen_addr = mem_addr; seen_wdata = mem_wdata; seen_be = mem_be; seen_we = mem_we;
                end else if (mem_addr !== seen_addr || mem_wdata !== seen_wdata ||
                             mem_be !== seen_be || mem_we !== seen_we) begin
                    unstable = 1'b1;
                end
                n_req++;
            end
            if (c > 1 && stall !== 1'b1) done_cycle = c;
            @(posedge clk); #1;
            datamem_en = 1'b0; mem_ready = 1'b0;
        end
        if (done_cycle < 0) begin
            checks++; errors++;
            $display("FAIL txn_budget: no DONE within 40 cycles, addr=%h", t_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; datamem_en = 1'b0; rw = 1'b1; size = 1'b0; addr = 32'h0;
        st_data = 32'hFFFF_FFFF; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL rst_mem_req: got %b need 0", mem_req); end
        checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
        checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata); end
        checks++; if (mem_be !== 4'b0000)   begin errors++; $display("FAIL rst_mem_be: got %b need 0000", mem_be); end
        checks++; if (load_valid !== 1'b0)  begin errors++; $display("FAIL rst_load_valid: got %b need 0", load_valid); end
        checks++; if (load_data !== 32'h0)  begin errors++; $display("FAIL rst_load_data: got %h need 0", load_data); end
        checks++; if (fault !== 2'b00)      begin errors++; $display("FAIL rst_fault: got %b need 00", fault); end
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL rst_stall: got %b need 0", stall); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        push_exp(1'b1, 32'hDEAD_BEEF, 2'b00);
        run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++; if (stall_bits[3:1] !== 3'b011) begin errors++; $display("FAIL wl_stall: got %b need 011 (c3..c1)", stall_bits[3:1]); end
        checks++; if (lv_cycle != 3) begin errors++; $display("FAIL wl_lv_cycle: got %0d need 3", lv_cycle); end
        checks++; if (seen_addr !== 32'h100 || seen_be !== 4'b1111 || seen_we !== 1'b0)
            begin errors++; $display("FAIL wl_req: addr=%h be=%b we=%b need 00000100 1111 0", seen_addr, seen_be, seen_we); end
    endtask

    task automatic test_byte_load();
        push_exp(1'b1, 32'h0000_00AA, 2'b00);
        run_txn(1'b1, 1'b1, 32'h0000_0103, 32'h0, 32'hAABB_CCDD, 0);
        checks++; if (seen_addr !== 32'h100 || seen_be !== 4'b1000)
            begin errors++; $display("FAIL bl_req: addr=%h be=%b need 00000100 1000", seen_addr, seen_be); end
        // Remaining lanes with varied data and wait states.
        for (int ln = 0; ln < 3; ln++) begin
            logic [31:0] rd;
            rd = $urandom;
            push_exp(1'b1, byte_of(rd, 2'(ln)), 2'b00);
            run_txn(1'b1, 1'b1, 32'h0000_0400 + 32'(ln), 32'h0, rd, ln);
            checks++; if (seen_be !== (4'b0001 << ln) || n_req != ln + 1 || unstable)
                begin errors++; $display("FAIL bl_lane%0d: be=%b n_req=%0d unstable=%b need be=%b n_req=%0d", ln, seen_be, n_req, unstable, 4'b0001 << ln, ln + 1); end
        end
    endtask

    task automatic test_stores();
        run_txn(1'b0, 1'b1, 32'h0000_0201, 32'h1234_56EF, 32'h0, 0);
        checks++; if (seen_we !== 1'b1 || seen_be !== 4'b0010 || seen_wdata !== 32'hEFEF_EFEF || seen_addr !== 32'h200)
            begin errors++; $display("FAIL bs_req: we=%b be=%b wdata=%h addr=%h need 1 0010 efefefef 00000200", seen_we, seen_be, seen_wdata, seen_addr); end
        checks++; if (lv_cycle != -1) begin errors++; $display("FAIL bs_lv: load_valid at cycle %0d need never", lv_cycle); end
        run_txn(1'b0, 1'b0, 32'h0000_0A08, 32'hCAFE_F00D, 32'h0, 2);
        checks++; if (seen_we !== 1'b1 || seen_be !== 4'b1111 || seen_wdata !== 32'hCAFE_F00D || unstable || n_req != 3)
            begin errors++; $display("FAIL ws_req: we=%b be=%b wdata=%h unstable=%b n_req=%0d need 1 1111 cafef00d 0 3", seen_we, seen_be, seen_wdata, unstable, n_req); end
    endtask

    task automatic test_misaligned();
        push_exp(1'b0, 32'h0, 2'b01);
        run_txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0);
        checks++; if (n_req != 0 || done_cycle != 2 || lv_cycle != -1)
            begin errors++; $display("FAIL mis: n_req=%0d done=%0d lv=%0d need 0 2 -1", n_req, done_cycle, lv_cycle); end
    endtask

    task automatic test_timeout();
        push_exp(1'b0, 32'h0, 2'b10);
        run_txn(1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'h2222_2222, 99);
        checks++; if (n_req != 4 || done_cycle != 6 || lv_cycle != -1)
            begin errors++; $display("FAIL to: n_req=%0d done=%0d lv=%0d need 4 6 -1", n_req, done_cycle, lv_cycle); end
        @(negedge clk);
        checks++; if (stall !== 1'b0 || fault !== 2'b00 || mem_req !== 1'b0)
            begin errors++; $display("FAIL to_idle: stall=%b fault=%b mem_req=%b need 0 00 0", stall, fault, mem_req); end
        @(posedge clk); #1;
        // Ready arriving on the last allowed cycle completes normally.
        push_exp(1'b1, 32'h3344_5566, 2'b00);
        run_txn(1'b1, 1'b0, 32'h0000_0804, 32'h0, 32'h3344_5566, 3);
        checks++; if (n_req != 4 || lv_cycle != 6)
            begin errors++; $display("FAIL to_ready_wins: n_req=%0d lv=%0d need 4 6", n_req, lv_cycle); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b0, 32'h0000_0C00, 32'h0BAD_C0DE, 32'h0, 0);
        push_exp(1'b1, 32'h0000_0077, 2'b00);
        run_txn(1'b1, 1'b1, 32'h0000_0C02, 32'h0, 32'h1177_2233, 0);
        checks++; if (stall_bits[3:1] !== 3'b011 || lv_cycle != 3 || seen_be !== 4'b0100)
            begin errors++; $display("FAIL b2b: stall=%b lv=%0d be=%b need 011 3 0100", stall_bits[3:1], lv_cycle, seen_be); end
    endtask

    task automatic test_ready_outside_req();
        mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
        repeat (3) @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || load_data === 32'h9999_9999)
            begin errors++; $display("FAIL idle_ready: stall=%b mem_req=%b load_data=%h need 0 0 unchanged", stall, mem_req, load_data); end
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        datamem_en = 1'b1; rw = 1'b1; size = 1'b0; addr = 32'h0000_0300; mem_ready = 1'b0;
        @(posedge clk); #1;
        datamem_en = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req: mem_req=%b need 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL rmid_async: mem_req=%b stall=%b need 0 0", mem_req, stall); end
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (load_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0)
                begin errors++; $display("FAIL rmid_after%0d: lv=%b stall=%b mem_req=%b need 0 0 0", i, load_valid, stall, mem_req); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_stores();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_ready_outside_req();
        test_reset_mid_req();
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected reports never seen, need 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
